// File: rtl/inst_mem_sync.sv
// Synchronous-read instruction memory for the IF stage with a registered fetch
// path (stall/flush aware) and a sequential word-by-word program loader.
module inst_mem_sync #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP        = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           if_addr,
  input  logic                  if_req,
  input  logic                  if_stall,
  input  logic                  if_flush,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  addr_err,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  ld_busy,
  output logic                  ld_done,
  output logic [ADDR_WIDTH:0]   ld_count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, LOAD} ld_state_e;

  ld_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   ld_count_q, ld_count_d;
  logic                  ld_done_q, ld_done_d;
  logic                  wr_en, wr_fin;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] inst_q;
  logic                  inst_valid_q, addr_err_q;
  logic                  fetch_err;
  logic [ADDR_WIDTH-1:0] fetch_idx;

  // A load ends on an explicit last word or when the top address is written.
  assign wr_en  = (state_q == LOAD) && ld_valid && !rst;
  assign wr_fin = wr_en && (ld_last || (wr_ptr_q == {ADDR_WIDTH{1'b1}}));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      ld_count_q <= '0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      ld_count_q <= ld_count_d;
      ld_done_q  <= ld_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    ld_count_d = ld_count_q;
    ld_done_d  = wr_fin;
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          ld_count_d = '0;
        end
      end
      LOAD: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          if (ld_count_q != (ADDR_WIDTH+1)'(DEPTH))
            ld_count_d = ld_count_q + (ADDR_WIDTH+1)'(1);
          if (wr_fin)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array contents survive reset on purpose: a reset must not wipe the program.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_q] <= ld_data;
  end

  assign fetch_err = (if_addr[1:0] != 2'b00) || ((if_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign fetch_idx = if_addr[ADDR_WIDTH+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else if (if_flush) begin
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else if (if_stall) begin
      inst_q       <= inst_q;
      inst_valid_q <= inst_valid_q;
      addr_err_q   <= addr_err_q;
    end else if (state_q == LOAD) begin
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
    end else if (if_req) begin
      if (fetch_err) begin
        inst_q       <= NOP;
        inst_valid_q <= 1'b0;
        addr_err_q   <= 1'b1;
      end else begin
        inst_q       <= mem[fetch_idx];
        inst_valid_q <= 1'b1;
        addr_err_q   <= 1'b0;
      end
    end else begin
      inst_valid_q <= 1'b0;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign addr_err   = addr_err_q;
  assign ld_ready   = (state_q == LOAD);
  assign ld_busy    = (state_q == LOAD);
  assign ld_done    = ld_done_q;
  assign ld_count   = ld_count_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed plus randomized bench for inst_mem_sync, checked every cycle against
// a behavioural model of the fetch/load rules.
module tb_inst_mem_sync;
  localparam int              AW    = 7;
  localparam int              DW    = 32;
  localparam int              DEPTH = 1 << AW;
  localparam logic [DW-1:0]   NOPW  = '0;

  logic          clk = 1'b0;
  logic          rst, if_req, if_stall, if_flush;
  logic [31:0]   if_addr;
  logic [DW-1:0] inst;
  logic          inst_valid, addr_err;
  logic          ld_start, ld_valid, ld_last;
  logic [DW-1:0] ld_data;
  logic          ld_ready, ld_busy, ld_done;
  logic [AW:0]   ld_count;

  always #5 clk = ~clk;

  inst_mem_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NOP(NOPW)) dut (
    .clk(clk), .rst(rst), .if_addr(if_addr), .if_req(if_req),
    .if_stall(if_stall), .if_flush(if_flush), .inst(inst),
    .inst_valid(inst_valid), .addr_err(addr_err), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
    .ld_count(ld_count)
  );

  int vectors = 0, miscompares = 0;

  // Reference model: program image, loader progress and expected outputs.
  logic [DW-1:0] mmem [DEPTH];
  bit            m_load;
  int            m_ptr, m_cnt;
  logic [DW-1:0] e_inst;
  logic          e_vld, e_err, e_done;
  logic [DW-1:0] word0;
  int            done_pulses;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rst = 0; if_req = 0; if_stall = 0; if_flush = 0; if_addr = '0;
    ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
  endtask

  // Predict one edge from the current inputs, advance, then compare all outputs.
  task automatic cyc();
    bit fin;
    if (rst) begin
      m_load = 0; m_ptr = 0; m_cnt = 0;
      e_inst = NOPW; e_vld = 0; e_err = 0; e_done = 0;
    end else begin
      fin = m_load && ld_valid && (ld_last || m_ptr == DEPTH - 1);
      if (if_flush) begin
        e_inst = NOPW; e_vld = 0; e_err = 0;
      end else if (if_stall) begin
        // outputs hold
      end else if (m_load) begin
        e_inst = NOPW; e_vld = 0;
      end else if (if_req) begin
        if ((if_addr % 4) != 0 || if_addr >= 4 * DEPTH) begin
          e_inst = NOPW; e_vld = 0; e_err = 1;
        end else begin
          e_inst = mmem[if_addr / 4]; e_vld = 1; e_err = 0;
        end
      end else begin
        e_vld = 0;
      end
      if (m_load && ld_valid) begin
        mmem[m_ptr] = ld_data;
        m_ptr++;
        if (m_cnt < DEPTH) m_cnt++;
      end
      e_done = fin;
      if (!m_load && ld_start) begin
        m_load = 1; m_ptr = 0; m_cnt = 0;
      end else if (fin) begin
        m_load = 0;
      end
    end
    @(posedge clk); #1;
    if (ld_done === 1'b1) done_pulses++;
    chk("inst",       inst,       e_inst);
    chk("inst_valid", inst_valid, e_vld);
    chk("addr_err",   addr_err,   e_err);
    chk("ld_done",    ld_done,    e_done);
    chk("ld_busy",    ld_busy,    m_load);
    chk("ld_ready",   ld_ready,   m_load);
    chk("ld_count",   ld_count,   m_cnt);
  endtask

  task automatic fetch(input logic [31:0] a);
    clr(); if_req = 1; if_addr = a; cyc();
  endtask

  initial begin
    clr();
    rst = 1; cyc(); cyc();
    chk("rst_inst", inst, 32'h0);
    chk("rst_count", ld_count, 0);

    // Full array: 128 words, no last marker
    clr(); ld_start = 1; cyc();
    for (int i = 0; i < DEPTH; i++) begin
      clr(); ld_valid = 1; ld_data = $urandom;
      if (i == 0) word0 = ld_data;
      cyc();
    end
    chk("full_count", ld_count, 128);
    chk("full_done", ld_done, 1);
    chk("full_busy", ld_busy, 0);
    clr(); ld_valid = 1; ld_data = 32'hDEAD_BEEF; cyc();
    fetch(32'h0);
    chk("full_mem0", inst, word0);

    // Load then fetch
    done_pulses = 0;
    clr(); ld_start = 1; cyc();
    clr(); ld_valid = 1; ld_data = 32'h2001_0005; cyc();
    ld_data = 32'h2002_000A; cyc();
    ld_data = 32'h0022_1820; ld_last = 1; cyc();
    chk("ld3_done", ld_done, 1);
    chk("ld3_count", ld_count, 3);
    clr(); cyc(); cyc();
    chk("ld3_pulses", done_pulses, 1);
    fetch(32'h0); chk("pc0", inst, 32'h2001_0005); chk("pc0_v", inst_valid, 1);
    fetch(32'h4); chk("pc4", inst, 32'h2002_000A);
    fetch(32'h8); chk("pc8", inst, 32'h0022_1820);

    // Stall / flush
    fetch(32'h4);
    for (int i = 0; i < 3; i++) begin
      clr(); if_req = 1; if_addr = 32'h8; if_stall = 1; cyc();
      chk("stall_hold", inst, 32'h2002_000A);
    end
    clr(); if_stall = 1; if_flush = 1; cyc();
    chk("flush_inst", inst, 32'h0);
    chk("flush_v", inst_valid, 0);

    // Address errors
    fetch(32'h6);
    chk("mis_err", addr_err, 1); chk("mis_v", inst_valid, 0); chk("mis_inst", inst, 32'h0);
    fetch(32'h200);
    chk("oor_err", addr_err, 1);
    fetch(32'h0);
    chk("ok_err", addr_err, 0);

    // Reset mid-load
    clr(); ld_start = 1; cyc();
    clr(); ld_valid = 1; ld_data = 32'hAAAA_0001; cyc();
    ld_data = 32'hBBBB_0002; cyc();
    clr(); rst = 1; cyc();
    chk("rml_busy", ld_busy, 0); chk("rml_count", ld_count, 0); chk("rml_v", inst_valid, 0);
    fetch(32'h4);
    chk("rml_word", inst, 32'hBBBB_0002);

    // Fetch blocked during load
    clr(); if_req = 1; ld_start = 1; cyc();
    for (int i = 0; i < 3; i++) begin
      clr(); if_req = 1; ld_valid = 1; ld_data = 32'h1000_0000 + i; ld_last = (i == 2); cyc();
      chk("blk_v", inst_valid, 0);
    end
    chk("blk_done", ld_done, 1);
    clr(); if_req = 1; cyc();
    chk("blk_after_v", inst_valid, 1);
    chk("blk_after", inst, 32'h1000_0000);

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      clr();
      rst      = ($urandom_range(0, 63) == 0);
      if_flush = ($urandom_range(0, 7) == 0);
      if_stall = ($urandom_range(0, 3) == 0);
      if_req   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       if_addr = $urandom;
        1:       if_addr = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
        default: if_addr = $urandom_range(0, DEPTH - 1) * 4;
      endcase
      ld_start = ($urandom_range(0, 15) == 0);
      ld_valid = $urandom_range(0, 1);
      ld_last  = ($urandom_range(0, 3) == 0);
      ld_data  = $urandom;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_mem_sync.md
# inst_mem_sync

Parametrised, synchronous-read instruction memory for the IF stage of the 5-stage MIPS pipeline, replacing the fixed 128-word combinational array. It adds a registered fetch path that honours pipeline stall and flush, plus a sequential loader port that programs the array word by word at run time. The IF stage drives the PC in, and IF/ID consumes `inst`/`inst_valid` one cycle later.

## Interface
- `ADDR_WIDTH`, default 7: word-address bits. DEPTH = 2^ADDR_WIDTH words, so the default is 128 words and PC bits [8:2].
- `DATA_WIDTH`, default 32: instruction width.
- `NOP`, default 32'h0000_0000: word driven on flush, error or blocked fetch.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_addr` in 32: byte PC from the IF stage.
- `if_req` in 1: fetch request.
- `if_stall` in 1: hold the current output.
- `if_flush` in 1: squash the next output.
- `inst` out DATA_WIDTH: fetched instruction, registered.
- `inst_valid` out 1: `inst` holds a real fetched word.
- `addr_err` out 1: the last accepted fetch was misaligned or out of range.
- `ld_start` in 1: begin a program load.
- `ld_valid` in 1: `ld_data` is valid.
- `ld_data` in DATA_WIDTH: word to write.
- `ld_last` in 1: marks the final word of the load.
- `ld_ready` out 1: loader accepts a word this cycle.
- `ld_busy` out 1: loader is in LOAD.
- `ld_done` out 1: one-cycle pulse when a load completes.
- `ld_count` out ADDR_WIDTH+1: number of words written by the current or last load.

## Operation
- Storage is a DEPTH×DATA_WIDTH array. It is not cleared by `rst`; contents persist across reset.
- Loader FSM has two states, IDLE and LOAD.
  - IDLE→LOAD when `ld_start`=1. This clears `wr_ptr` and `ld_count`.
  - In LOAD, `ld_ready`=1 and `ld_busy`=1.
  - Each cycle with `ld_valid & ld_ready` writes `ld_data` to mem[`wr_ptr`], then increments `wr_ptr` and `ld_count`.
  - LOAD→IDLE after a write with `ld_last`=1, or after the write to address DEPTH-1 (array full). `ld_done` pulses on the cycle after that write.
  - `ld_start` during LOAD is ignored. `ld_valid` in IDLE is ignored (no write).
- Fetch is accepted when state=IDLE, `if_req`=1 and `if_stall`=0.
  - Error condition: `if_addr[1:0]`≠0, or `if_addr[31:ADDR_WIDTH+2]`≠0.
  - With no error: `inst`←mem[`if_addr[ADDR_WIDTH+1:2]`], `inst_valid`←1, `addr_err`←0.
  - With an error: `inst`←NOP, `inst_valid`←0, `addr_err`←1.
- Output update priority, highest first:
  - `rst`: all outputs go to reset values.
  - `if_flush`: `inst`←NOP, `inst_valid`←0, `addr_err`←0.
  - `if_stall`: outputs hold.
  - Loader in LOAD: `inst`←NOP, `inst_valid`←0.
  - Accepted fetch: per the rules above.
  - `if_req`=0: `inst_valid`←0, `inst` holds.
- `ld_start` in the same cycle as an accepted fetch: the fetch completes normally; fetches are blocked from the next cycle on.

## Timing
- Reset values: `inst`=NOP, `inst_valid`=0, `addr_err`=0, `ld_ready`=0, `ld_busy`=0, `ld_done`=0, `ld_count`=0, state=IDLE, `wr_ptr`=0.
- Fetch latency is 1 cycle. The address is sampled at edge N and `inst` is valid after edge N.
- Stall holds `inst`, `inst_valid` and `addr_err` for every stalled cycle. Flush takes effect at the next edge.
- `ld_ready` and `ld_busy` are registered from the state and go high the cycle after `ld_start` is sampled.
- A word written at edge N is readable by a fetch sampled at edge N+1 or later. Reads and writes never overlap, because fetch is blocked in LOAD.
- `rst` during LOAD forces IDLE and clears `wr_ptr`/`ld_count`. Words already written stay in the array.
- `ld_count` saturates at DEPTH.

## Test plan
- Load then fetch: pulse `ld_start`, stream 0x2001_0005, 0x2002_000A, 0x0022_1820 with `ld_last` on the third word → `ld_done` pulses once, `ld_count`=3. Fetches of PC 0x0, 0x4, 0x8 then return those words, each with `inst_valid`=1, one cycle after the request.
- Stall/flush: fetch PC 0x4, then hold `if_stall` for 3 cycles → `inst`=0x2002_000A held. Then assert `if_flush` and `if_stall` together → `inst`=0, `inst_valid`=0.
- Address errors: fetch PC 0x6 (misaligned) → `addr_err`=1, `inst_valid`=0, `inst`=0. Fetch PC 0x200 with ADDR_WIDTH=7 → `addr_err`=1.
- Full array: load 128 words with no `ld_last` → state returns to IDLE after the 128th write, `ld_count`=128, `ld_done`=1. A 129th `ld_valid` is ignored and mem[0] is unchanged.
- Reset mid-load: write 2 words, assert `rst` → `ld_busy`=0, `ld_count`=0, `inst_valid`=0. A fetch of PC 0x4 then returns the second loaded word.
- Fetch blocked during load: `if_req`=1 throughout LOAD → `inst_valid`=0 on every LOAD cycle. A fetch of PC 0x0 succeeds on the cycle after `ld_done`.
